// File: rtl/mem_responder.sv
// mem_responder
//   Unified instruction/data memory for the multicycle MIPS core. The memory
//   answers fetch, load and store requests through a request/ready handshake.
//   Each request gets WAIT_CYCLES wait states before its one-cycle MemReady
//   pulse.
//
// Parameters
//   ADDR_W      : word-address bits (array of 2^ADDR_W 32-bit words)
//   WAIT_CYCLES : wait states before each response (0..15)
//
// Ports
//   clk, rst    : clock, asynchronous active-high reset
//   MemRead     : read request, held until MemReady
//   MemWrite    : write request, held until MemReady (a write wins if both are high)
//   Addr        : byte address; bits above ADDR_W+1 are ignored (address wraps)
//   WriteData   : store data
//   ReadData    : registered read data; holds until the next read commits
//   MemReady    : one-cycle completion pulse (RESP state)
//   Busy        : high in WAIT and RESP
//   AddrErr     : misaligned-access flag during RESP (alignment check only)
//
// Optional feature
//   MEM_ALIGN_CHECK_EN : when defined, an access with Addr[1:0] != 0 still
//   completes. Its write is dropped, ReadData is left unchanged, and AddrErr
//   is raised during RESP. When undefined, Addr[1:0] is ignored and AddrErr
//   is 0.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        Busy,
    output logic        AddrErr
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t              state, state_nxt;
    logic [3:0]          cnt, cnt_nxt;
    logic                accept, commit;

    // Operation latched at acceptance
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;

    // Operands used at commit. With zero wait states the commit happens on
    // the accepting edge, so the live inputs are used instead of the latches.
    logic                c_wr;
    logic [ADDR_W-1:0]   c_addr;
    logic [31:0]         c_wdata;
    logic                c_mis;
    logic                mem_we;

    logic [31:0]         mem [0:(1<<ADDR_W)-1];

    // Address bits above the array and the byte offset are don't-cares.
    logic                unused_addr;
    assign unused_addr = ^{Addr[31:ADDR_W+2], Addr[1:0]};

    // ---------------- FSM next state ----------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    accept  = 1'b1;
                    cnt_nxt = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- commit operand selection ----------------
    always_comb begin
        if (state == IDLE) begin
            c_wr    = MemWrite;
            c_addr  = Addr[ADDR_W+1:2];
            c_wdata = WriteData;
        end else begin
            c_wr    = wr_q;
            c_addr  = addr_q;
            c_wdata = wdata_q;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic mis_q;
    assign c_mis   = (state == IDLE) ? (Addr[1:0] != 2'b00) : mis_q;
    assign AddrErr = (state == RESP) && mis_q;
`else
    assign c_mis   = 1'b0;
    assign AddrErr = 1'b0;
`endif

    // ---------------- state / latches / read data ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            ReadData <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                wr_q    <= MemWrite;
                addr_q  <= Addr[ADDR_W+1:2];
                wdata_q <= WriteData;
            end
            if (commit && !c_wr && !c_mis)
                ReadData <= mem[c_addr];
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mis_q <= 1'b0;
        else if (accept)
            mis_q <= (Addr[1:0] != 2'b00);
    end
`endif

    // The array is not reset. The write is gated by rst so that a
    // zero-wait accept that coincides with reset cannot slip through.
    assign mem_we = commit && c_wr && !c_mis && !rst;

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[c_addr] <= c_wdata;
    end

    // Outputs decoded from state only
    assign MemReady = (state == RESP);
    assign Busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder. Three instances run with WAIT_CYCLES = 1, 0
// and 3. A per-instance word-array model predicts ReadData and the
// completion latency.
module tb_mem_responder;

    localparam int ADDR_W = 8;
    localparam int WCS [3] = '{1, 0, 3};

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mr, mw;
    logic [31:0] addr  [3];
    logic [31:0] wd    [3];
    logic [31:0] rdata [3];
    logic [2:0]  rdy, busy, aerr;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state: the 16 words used by the bench, and expected ReadData.
    logic [31:0] mm     [3][16];
    logic [31:0] rd_exp [3];

    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(1)) u_d0 (
        .clk(clk), .rst(rst), .MemRead(mr[0]), .MemWrite(mw[0]), .Addr(addr[0]),
        .WriteData(wd[0]), .ReadData(rdata[0]), .MemReady(rdy[0]), .Busy(busy[0]),
        .AddrErr(aerr[0]));
    mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) u_d1 (
        .clk(clk), .rst(rst), .MemRead(mr[1]), .MemWrite(mw[1]), .Addr(addr[1]),
        .WriteData(wd[1]), .ReadData(rdata[1]), .MemReady(rdy[1]), .Busy(busy[1]),
        .AddrErr(aerr[1]));
    mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(3)) u_d2 (
        .clk(clk), .rst(rst), .MemRead(mr[2]), .MemWrite(mw[2]), .Addr(addr[2]),
        .WriteData(wd[2]), .ReadData(rdata[2]), .MemReady(rdy[2]), .Busy(busy[2]),
        .AddrErr(aerr[2]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // One complete access on instance d. The request is held until MemReady
    // and then dropped. The call returns at the negedge after the pulse.
    task automatic acc(input int d, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] w);
        int  k;
        bit  got;
        bit  mis;
`ifdef MEM_ALIGN_CHECK_EN
        mis = (a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        @(negedge clk);
        mr[d] = rd; mw[d] = wr; addr[d] = a; wd[d] = w;
        k = 0; got = 0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (rdy[d]) got = 1;
            else chk("busy_wait", {31'd0, busy[d]}, 32'd1);
        end
        chk("latency", k, WCS[d] + 1);
        // Reference: a write wins over a simultaneous read; a misaligned
        // access (checked build only) changes nothing.
        if (!mis) begin
            if (wr) mm[d][a[5:2]] = w;
            else if (rd) rd_exp[d] = mm[d][a[5:2]];
        end
        chk("rdata", rdata[d], rd_exp[d]);
        chk("busy_resp", {31'd0, busy[d]}, 32'd1);
        chk("addrerr_resp", {31'd0, aerr[d]}, {31'd0, mis});
        mr[d] = 1'b0; mw[d] = 1'b0;
        @(negedge clk);
        chk("ready_width", {31'd0, rdy[d]}, 32'd0);
        chk("busy_idle", {31'd0, busy[d]}, 32'd0);
        chk("addrerr_idle", {31'd0, aerr[d]}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        rst = 1'b1;
        mr = '0; mw = '0;
        for (int d = 0; d < 3; d++) begin
            addr[d] = '0; wd[d] = '0; rd_exp[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_rdata", rdata[d], 32'd0);
            chk("rst_flags", {29'd0, rdy[d], busy[d], aerr[d]}, 32'd0);
        end
        rst = 1'b0;

        // Known contents for the words the bench touches
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 16; i++)
                acc(d, 1'b0, 1'b1, 32'(i << 2), $urandom);

        // Write then read back, WAIT_CYCLES=1
        acc(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        acc(0, 1'b1, 1'b0, 32'h10, 32'h0);
        chk("wr_rd_10", rdata[0], 32'hDEADBEEF);

        // Simultaneous request acts as a write; ReadData holds
        acc(0, 1'b1, 1'b1, 32'h8, 32'h12345678);
        chk("both_rdata_held", rdata[0], 32'hDEADBEEF);
        acc(0, 1'b1, 1'b0, 32'h8, 32'h0);
        chk("both_readback", rdata[0], 32'h12345678);

        // Address wrap: 0x400 aliases word 0
        acc(0, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5);
        acc(0, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("wrap", rdata[0], 32'hA5A5A5A5);

        // Misaligned write to 0x22, then read word 0x20
        acc(0, 1'b0, 1'b1, 32'h22, 32'hBAD00001);
        acc(0, 1'b1, 1'b0, 32'h20, 32'h0);

        // Zero-wait back-to-back reads held continuously
        @(negedge clk);
        mr[1] = 1'b1; addr[1] = 32'h0;
        @(negedge clk);
        chk("b2b_r0", {30'd0, rdy[1], busy[1]}, 32'd3);
        chk("b2b_d0", rdata[1], mm[1][0]);
        addr[1] = 32'h4;
        @(negedge clk);
        chk("b2b_gap", {30'd0, rdy[1], busy[1]}, 32'd0);
        @(negedge clk);
        chk("b2b_r1", {30'd0, rdy[1], busy[1]}, 32'd3);
        chk("b2b_d1", rdata[1], mm[1][1]);
        rd_exp[1] = mm[1][1];
        mr[1] = 1'b0;
        @(negedge clk);
        chk("b2b_end", {30'd0, rdy[1], busy[1]}, 32'd0);

        // Reset during the 2nd WAIT cycle discards the write
        @(negedge clk);
        mw[2] = 1'b1; addr[2] = 32'h20; wd[2] = 32'h1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_busy_before", {31'd0, busy[2]}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy_async", {31'd0, busy[2]}, 32'd0);
        chk("midrst_ready", {31'd0, rdy[2]}, 32'd0);
        for (int d = 0; d < 3; d++) rd_exp[d] = 32'd0;
        mw[2] = 1'b0;
        @(negedge clk);
        chk("midrst_ready_hold", {31'd0, rdy[2]}, 32'd0);
        rst = 1'b0;
        acc(2, 1'b1, 1'b0, 32'h20, 32'h0);

        // Randomized accesses with wrapping upper bits and odd offsets
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 40; i++) begin
                op = $urandom_range(0, 2);
                a  = (32'($urandom_range(0, 7)) << 10) | (32'($urandom_range(0, 15)) << 2);
                if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
                acc(d, op != 1, op != 0, a, $urandom);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
